// File: rtl/my_ycbcr_pkg.sv
// video_pkg: shared widths, BT.601 full-range coefficients, offset and pipeline depth for my_ycbcr
package video_pkg;
  localparam int PIX_W = 24;
  localparam int COMP_W = 8;
  localparam int DEPTH = 3;
  typedef logic signed [16:0] coef_t;
  typedef logic signed [18:0] sum_t;
  localparam coef_t K_YR = 17'sd77;
  localparam coef_t K_YG = 17'sd150;
  localparam coef_t K_YB = 17'sd29;
  localparam coef_t K_CBR = -17'sd43;
  localparam coef_t K_CBG = -17'sd85;
  localparam coef_t K_CBB = 17'sd128;
  localparam coef_t K_CRR = 17'sd128;
  localparam coef_t K_CRG = -17'sd107;
  localparam coef_t K_CRB = -17'sd21;
  localparam sum_t OFS = 19'sd128;
  typedef struct packed {
    logic sel;
    logic user;
    logic last;
    logic [PIX_W-1:0] data;
  } beat_t;
endpackage

// File: rtl/my_ycbcr_if.sv
// my_ycbcr_if: AXI4-Stream video bus (tdata/tvalid/tready/tuser/tlast) with master and slave modports
interface my_ycbcr_if;
  import video_pkg::*;
  logic [PIX_W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;
  modport master(output tdata, tvalid, tuser, tlast, input tready);
  modport slave(input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/my_ycbcr_lane.sv
// ycbcr_lane: one colour component; ports clk, ce, r/g/b in, q = clamped component out of the sum stage (combinational)
module ycbcr_lane
  import video_pkg::*;
#(
  parameter coef_t KR = 17'sd0,
  parameter coef_t KG = 17'sd0,
  parameter coef_t KB = 17'sd0,
  parameter sum_t BIAS = 19'sd0
) (
  input  logic clk,
  input  logic ce,
  input  logic [COMP_W-1:0] r,
  input  logic [COMP_W-1:0] g,
  input  logic [COMP_W-1:0] b,
  output logic [COMP_W-1:0] q
);
  coef_t pr, pg, pb;
  sum_t s, t;
  always_ff @(posedge clk) begin
    if (ce) begin
      pr <= KR * $signed(17'(r));
      pg <= KG * $signed(17'(g));
      pb <= KB * $signed(17'(b));
      s <= 19'(pr) + 19'(pg) + 19'(pb) + OFS;
    end
  end
  always_comb begin
    t = (s >>> 8) + BIAS;
    q = t[18] ? '0 : (|t[17:8]) ? '1 : t[7:0];
  end
endmodule

// File: rtl/my_ycbcr.sv
// my_ycbcr: 3-stage RGB->YCbCr (or bypass when Sel) AXI4-Stream converter; ports clk, rst, Sel, s_axis_video (slave), m_axis_video (master)
module my_ycbcr
  import video_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic Sel,
  my_ycbcr_if.slave s_axis_video,
  my_ycbcr_if.master m_axis_video
);
  logic ce, v1, v2;
  beat_t b1, b2;
  logic [COMP_W-1:0] y, cb, cr;
  assign ce = !m_axis_video.tvalid || m_axis_video.tready;
  assign s_axis_video.tready = ce;
  ycbcr_lane #(.KR(K_YR), .KG(K_YG), .KB(K_YB), .BIAS(19'sd0)) u_y (
    .clk, .ce, .r(s_axis_video.tdata[23:16]), .g(s_axis_video.tdata[15:8]),
    .b(s_axis_video.tdata[7:0]), .q(y)
  );
  ycbcr_lane #(.KR(K_CBR), .KG(K_CBG), .KB(K_CBB), .BIAS(OFS)) u_cb (
    .clk, .ce, .r(s_axis_video.tdata[23:16]), .g(s_axis_video.tdata[15:8]),
    .b(s_axis_video.tdata[7:0]), .q(cb)
  );
  ycbcr_lane #(.KR(K_CRR), .KG(K_CRG), .KB(K_CRB), .BIAS(OFS)) u_cr (
    .clk, .ce, .r(s_axis_video.tdata[23:16]), .g(s_axis_video.tdata[15:8]),
    .b(s_axis_video.tdata[7:0]), .q(cr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      m_axis_video.tvalid <= 1'b0;
      m_axis_video.tuser <= 1'b0;
      m_axis_video.tlast <= 1'b0;
      m_axis_video.tdata <= '0;
    end else if (ce) begin
      v1 <= s_axis_video.tvalid;
      b1 <= '{Sel, s_axis_video.tuser, s_axis_video.tlast, s_axis_video.tdata};
      v2 <= v1;
      b2 <= b1;
      m_axis_video.tvalid <= v2;
      m_axis_video.tuser <= b2.user;
      m_axis_video.tlast <= b2.last;
      m_axis_video.tdata <= b2.sel ? b2.data : {y, cb, cr};
    end
  end
endmodule

// File: tb/tb_my_ycbcr.sv
// tb_my_ycbcr: randomized scoreboard bench for my_ycbcr against an arithmetic reference model
module tb_my_ycbcr;
  import video_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  my_ycbcr_if s_if();
  my_ycbcr_if m_if();
  my_ycbcr dut(.clk(clk), .rst(rst), .Sel(sel), .s_axis_video(s_if), .m_axis_video(m_if));
  always #5 clk = ~clk;
  typedef struct {
    logic [25:0] v;
    int c;
    bit lat;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_pct = 100;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] clip(input int v);
    return v < 0 ? 8'd0 : v > 255 ? 8'hff : 8'(v);
  endfunction
  function automatic logic [23:0] model(input logic [23:0] p, input logic s);
    int r, g, b, y, cb, cr;
    if (s) return p;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b + 128) >>> 8;
    cb = ((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128;
    cr = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128;
    return {clip(y), clip(cb), clip(cr)};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic send(input logic [23:0] d, input logic u, input logic l, input logic s,
                      input logic [23:0] e, input bit lat);
    int n = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata = d;
      s_if.tuser = u;
      s_if.tlast = l;
      sel = s;
      m_if.tready = $urandom_range(0, 99) < rdy_pct;
      #1;
      acc = s_if.tready;
      n++;
      if (!acc && n > 1000) begin
        $display("FAIL send_timeout: got tready=0 expected 1");
        $fatal(1);
      end
    end
    q.push_back('{{u, l, e}, cyc, lat});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_if.tvalid = 1'b0;
      s_if.tdata = 24'($urandom);
      s_if.tuser = 1'($urandom);
      s_if.tlast = 1'($urandom);
      sel = 1'($urandom);
      m_if.tready = $urandom_range(0, 99) < rdy_pct;
    end
  endtask
  logic pv = 1'b0, pr = 1'b0;
  logic [25:0] pd = '0;
  always @(negedge clk) begin
    logic [25:0] cur;
    exp_t e;
    #2;
    cur = {m_if.tuser, m_if.tlast, m_if.tdata};
    if (!rst) begin
      if (pv && !pr) begin
        chk("stall_valid", 32'(m_if.tvalid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(pd));
      end
      if (m_if.tvalid && !m_if.tready) chk("stall_s_tready", 32'(s_if.tready), 32'd0);
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) chk("unexpected_beat", 32'(cur), 32'hdead);
        else begin
          e = q.pop_front();
          chk("beat", 32'(cur), 32'(e.v));
          if (e.lat) chk("latency", 32'(cyc - e.c), 32'(DEPTH));
        end
      end
    end
    pv = rst ? 1'b0 : m_if.tvalid;
    pr = m_if.tready;
    pd = cur;
  end
  logic [23:0] vin[5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
  logic [23:0] vexp[5] = '{24'hFF8080, 24'h008080, 24'h4D55FF, 24'h952B15, 24'h1DFF6B};
  initial begin
    logic [23:0] d;
    logic s;
    int w;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tuser = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_m_tuser", 32'(m_if.tuser), 32'd0);
    chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      send(vin[i], 1'b0, 1'b0, 1'b0, vexp[i], 1);
      idle(4);
    end
    send(24'h123456, 1'b0, 1'b0, 1'b1, 24'h123456, 1);
    send(24'h123456, 1'b0, 1'b0, 1'b0, 24'h2E976C, 1);
    idle(5);
    for (int i = 0; i < 640; i++) begin
      d = 24'($urandom);
      send(d, i == 0, i == 639, 1'b0, model(d, 1'b0), 1);
    end
    idle(5);
    for (int i = 0; i < 5; i++) begin
      d = 24'($urandom);
      send(d, i == 0, i == 4, 1'b0, model(d, 1'b0), 0);
    end
    rdy_pct = 0;
    idle(10);
    rdy_pct = 100;
    idle(6);
    for (int i = 0; i < 28; i++) begin
      d = 24'($urandom);
      if (i % 7 < 4) send(d, 1'b0, i % 7 == 3, 1'b0, model(d, 1'b0), 1);
      else idle(1);
    end
    idle(5);
    rdy_pct = 70;
    for (int i = 0; i < 300; i++) begin
      d = 24'($urandom);
      s = 1'($urandom);
      send(d, 1'($urandom), 1'($urandom), s, model(d, s), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_pct = 100;
    idle(8);
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom);
      send(d, 1'b0, 1'b0, 1'b0, model(d, 1'b0), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("flush_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("flush_s_tready", 32'(s_if.tready), 32'd1);
    idle(6);
    d = 24'h0000FF;
    send(d, 1'b1, 1'b1, 1'b0, 24'h1DFF6B, 1);
    w = 0;
    while (q.size() != 0 && w < 50) begin
      idle(1);
      w++;
    end
    idle(2);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/my_ycbcr.md
# my_ycbcr

Streaming RGB-to-YCbCr colour-space converter on the camera video path, between the camera AXI4-Stream source and the slant frame memory. It accepts 24-bit RGB pixels over AXI4-Stream and emits 24-bit YCbCr 4:4:4 (BT.601 full-range, integer coefficients) or, when bypass is selected, the unmodified RGB. Both outputs have the same latency, and frame/line sideband is carried alongside the pixel.

## Interface
Parameters: none; latency and coefficients are fixed.
- clk  in  1  video clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- Sel  in  1  0 = convert to YCbCr, 1 = bypass RGB; sampled per accepted beat
- s_axis_video_tdata  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B
- s_axis_video_tvalid  in  1  input beat valid
- s_axis_video_tready  out  1  input beat accepted when high with tvalid
- s_axis_video_tuser  in  1  start of frame (first pixel)
- s_axis_video_tlast  in  1  end of line (last pixel)
- m_axis_video_tdata  out  24  [23:16]=Y, [15:8]=Cb, [7:0]=Cr (RGB layout in bypass)
- m_axis_video_tvalid  out  1  output beat valid
- m_axis_video_tready  in  1  downstream ready
- m_axis_video_tuser  out  1  delayed s tuser
- m_axis_video_tlast  out  1  delayed s tlast

## Operation
- Y  = (77R + 150G + 29B + 128) >> 8
- Cb = ((−43R − 85G + 128B + 128) >>> 8) + 128
- Cr = ((128R − 107G − 21B + 128) >>> 8) + 128
- Signed arithmetic. Products are 17-bit signed; sums are 19-bit signed. `>>>` is an arithmetic (floor) shift. Each result is clamped to 0..255 before output.
- Bypass (Sel=1): tdata is passed unchanged through the same pipeline.
- Sel travels with each beat, so changing Sel mid-line affects only later beats.
- tuser and tlast are delayed identically to tdata. No beat is created, dropped or reordered.
- No frame/line state machine: each beat is treated independently.

## Timing
- 3-stage pipeline:
  - S1 registers products.
  - S2 registers sums.
  - S3 registers round/shift/clamp and mux.
- Latency: 3 clock-enabled cycles from accepted input beat to m tvalid.
- Global stall: ce = !m_axis_video_tvalid || m_axis_video_tready. s_axis_video_tready = ce (combinational).
- Each stage has a valid bit. A stage captures when ce=1; the input valid bit = s tvalid && ce.
- While m tvalid=1 and m tready=0, all stage registers and m outputs hold stable. AXI rules apply: no change of tdata/tuser/tlast while valid && !ready.
- Throughput: 1 beat/clk with m tready held high; bubbles in input propagate as bubbles.
- Reset: all valid bits, m_axis_video_tvalid, m_axis_video_tuser and m_axis_video_tlast are 0; m_axis_video_tdata is 0. s_axis_video_tready is 1 after reset (pipeline empty).
- Reset mid-stream flushes all in-flight beats; none reappear.
- Simultaneous accept and emit in one cycle is legal and required.

## Structure
- Shared package `video_pkg` holds:
  - pixel width (24) and component width (8);
  - the nine coefficients as signed localparams;
  - the offset constant 128;
  - the pipeline depth (3).
- One natural sub-module: `ycbcr_lane`, which computes one output component (three products, sum, round, clamp); instantiated three times. The top level holds the handshake, valid/sideband shift, and the Sel mux.

## Test plan
- Sel=0, rst deasserted, m tready=1, single beat (sample outputs exactly 3 clk after accept), tdata:
  - FFFFFF -> FF8080
  - 000000 -> 008080
  - FF0000 -> 4D55FF
  - 00FF00 -> 952B15
  - 0000FF -> 1DFF6B (Cb clamped from 256)
- Sel=1, tdata 123456 -> m tdata 123456 after 3 cycles; then toggle Sel=0 for next beat -> next output converted, previous one still 123456.
- Line of 640 back-to-back beats with tuser on beat 0 and tlast on beat 639, m tready=1 -> 640 outputs, tuser only on first, tlast only on last, no gaps.
- Backpressure: m tready low for 10 cycles while output valid -> s tready low, m tdata/tuser/tlast frozen; release -> stream resumes with no loss or duplication.
- Input gaps: tvalid pattern 4 on / 3 off -> outputs show the same pattern shifted by 3 cycles.
- Assert rst for 1 cycle with 3 beats in flight -> m tvalid 0 next cycle, s tready 1, flushed beats never appear.
